// File: rtl/life_engine.sv
// Double-buffered Game of Life engine: evaluates one cell per clock into the back bank and
// swaps banks only while swap_sync is high, so the displayed bank is never half-updated.
module life_engine #(
  parameter int LOG_W = 3,
  parameter int LOG_H = 3,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16,
  localparam int AW   = LOG_W + LOG_H
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             wr_data,
  input  logic             rnd_bit,
  input  logic             swap_sync,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_data,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] generation,
  output logic [AW:0]      alive_count,
  output logic             stable
);

  localparam int N  = 1 << AW;
  localparam int W  = 1 << LOG_W;
  localparam int H  = 1 << LOG_H;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPUTE,
    S_WAIT_SYNC,
    S_SWAP,
    S_RAND
  } state_t;

  state_t           state_q;
  logic [N-1:0]     bank_q [2];
  logic             sel_q;
  logic [AW-1:0]    idx_q;
  logic [AW:0]      pop_q;
  logic             diff_q;
  logic             done_q;
  logic [GEN_W-1:0] gen_q;
  logic [AW:0]      alive_q;
  logic             stable_q;

  logic [N-1:0]     disp_s;
  logic [LOG_W-1:0] x_s;
  logic [LOG_H-1:0] y_s;
  logic [3:0]       nbr_cnt_s;
  logic             cur_s;
  logic             cell_d;

  assign disp_s = bank_q[sel_q];
  assign x_s    = idx_q[LOG_W-1:0];
  assign y_s    = idx_q[AW-1:LOG_W];
  assign cur_s  = disp_s[idx_q];

  // Neighbour count of the current cell; negative or overflowing coordinates wrap via truncation.
  always_comb begin
    int  xi;
    int  yi;
    logic inr;
    nbr_cnt_s = 4'd0;
    xi        = 0;
    yi        = 0;
    inr       = 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xi  = int'(x_s) + dx;
        yi  = int'(y_s) + dy;
        inr = (xi >= 0) && (xi < W) && (yi >= 0) && (yi < H);
        if (!((dx == 0) && (dy == 0)) && ((WRAP != 0) || inr)) begin
          nbr_cnt_s = nbr_cnt_s + 4'(disp_s[{yi[LOG_H-1:0], xi[LOG_W-1:0]}]);
        end else begin
          nbr_cnt_s = nbr_cnt_s;
        end
      end
    end
    cell_d = (nbr_cnt_s == 4'd3) | (cur_s & (nbr_cnt_s == 4'd2));
  end

  // Engine FSM, both banks and all status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      sel_q     <= 1'b0;
      idx_q     <= '0;
      pop_q     <= '0;
      diff_q    <= 1'b0;
      done_q    <= 1'b0;
      gen_q     <= '0;
      alive_q   <= '0;
      stable_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_en) bank_q[sel_q][wr_addr] <= wr_data;
          if (cmd_valid) begin
            idx_q  <= '0;
            pop_q  <= '0;
            diff_q <= 1'b0;
            case (cmd_op)
              2'b00: state_q <= S_COMPUTE;
              2'b01: state_q <= S_RAND;
              2'b10: begin
                // Overrides a same-edge cell edit, which is the intended outcome of CLEAR.
                bank_q[sel_q] <= '0;
                gen_q         <= '0;
                alive_q       <= '0;
                stable_q      <= 1'b0;
                done_q        <= 1'b1;
              end
              default: done_q <= 1'b1;
            endcase
          end
        end
        S_COMPUTE: begin
          bank_q[~sel_q][idx_q] <= cell_d;
          pop_q                 <= pop_q + CW'(cell_d);
          diff_q                <= diff_q | (cell_d ^ cur_s);
          idx_q                 <= idx_q + AW'(1);
          if (&idx_q) state_q <= swap_sync ? S_SWAP : S_WAIT_SYNC;
        end
        S_WAIT_SYNC: begin
          if (swap_sync) state_q <= S_SWAP;
        end
        S_SWAP: begin
          sel_q    <= ~sel_q;
          gen_q    <= gen_q + GEN_W'(1);
          alive_q  <= pop_q;
          stable_q <= ~diff_q;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_RAND: begin
          bank_q[sel_q][idx_q] <= rnd_bit;
          idx_q                <= idx_q + AW'(1);
          if (&idx_q) begin
            gen_q    <= '0;
            alive_q  <= '0;
            stable_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = ~cmd_ready;
  assign rd_data     = disp_s[rd_addr];
  assign done        = done_q;
  assign generation  = gen_q;
  assign alive_count = alive_q;
  assign stable      = stable_q;

endmodule
